// File: rtl/bayer_mosaic_pkg.sv
// Shared definitions for the RGB-to-Bayer mosaic stage: channel encoding,
// address width, default frame geometry and the colour-filter lookup.
package bayer_mosaic_pkg;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } bayer_ch_e;

  localparam int ADDR_W     = 19;
  localparam int DEF_SIZE_X = 10;
  localparam int DEF_SIZE_Y = 10;

  // One raw beat as it sits in the output register or the skid entry.
  typedef struct packed {
    logic [7:0]        raw;
    logic [ADDR_W-1:0] addr;
    logic              sof;
    logic              eol;
    logic              last;
  } raw_beat_t;

  // Filter colour for a pixel whose phase-adjusted parities are (px, py).
  function automatic bayer_ch_e bayer_channel(input logic px, input logic py);
    bayer_ch_e ch;
    unique case ({py, px})
      2'b00:   ch = CH_G;
      2'b01:   ch = CH_B;
      2'b10:   ch = CH_R;
      default: ch = CH_G;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/bayer_mosaic_pos_counter.sv
// Pixel position tracker: tags each accepted beat with its column/row parity,
// linear address and line/frame markers, and resynchronises on start-of-frame.
module bayer_pos_counter
  import bayer_mosaic_pkg::*;
#(
  parameter int size_x = DEF_SIZE_X,
  parameter int size_y = DEF_SIZE_Y
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_adv,
  input  logic              i_sof,
  output logic              o_px,
  output logic              o_py,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_last,
  output logic              o_sof_err
);

  localparam int XW = (size_x > 1) ? $clog2(size_x) : 1;
  localparam int YW = (size_y > 1) ? $clog2(size_y) : 1;

  logic [XW-1:0]     r_cx;
  logic [YW-1:0]     r_cy;
  logic [ADDR_W-1:0] r_addr;
  logic              r_sof_err;

  logic [XW-1:0]     w_tx;
  logic [YW-1:0]     w_ty;
  logic [ADDR_W-1:0] w_taddr;
  logic              w_eol;
  logic              w_last;
  logic              w_at_origin;

  // A start-of-frame beat is forced to (0,0) regardless of where the counters were.
  assign w_tx        = i_sof ? '0 : r_cx;
  assign w_ty        = i_sof ? '0 : r_cy;
  assign w_taddr     = i_sof ? '0 : r_addr;
  assign w_eol       = (w_tx == XW'(size_x - 1));
  assign w_last      = w_eol && (w_ty == YW'(size_y - 1));
  assign w_at_origin = (r_cx == '0) && (r_cy == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cx      <= '0;
      r_cy      <= '0;
      r_addr    <= '0;
      r_sof_err <= 1'b0;
    end else if (i_adv) begin
      if (w_last) begin
        r_cx   <= '0;
        r_cy   <= '0;
        r_addr <= '0;
      end else if (w_eol) begin
        r_cx   <= '0;
        r_cy   <= w_ty + YW'(1);
        r_addr <= w_taddr + ADDR_W'(1);
      end else begin
        r_cx   <= w_tx + XW'(1);
        r_cy   <= w_ty;
        r_addr <= w_taddr + ADDR_W'(1);
      end
      if (i_sof && !w_at_origin) r_sof_err <= 1'b1;
    end
  end

  assign o_px      = w_tx[0];
  assign o_py      = w_ty[0];
  assign o_addr    = w_taddr;
  assign o_sof     = (w_tx == '0) && (w_ty == '0);
  assign o_eol     = w_eol;
  assign o_last    = w_last;
  assign o_sof_err = r_sof_err;

endmodule

// File: rtl/bayer_mosaic.sv
// RGB stream to single-channel Bayer raw stream, with an output register
// backed by a one-entry skid buffer so in_ready is fully registered.
module bayer_mosaic
  import bayer_mosaic_pkg::*;
#(
  parameter int         size_x = DEF_SIZE_X,
  parameter int         size_y = DEF_SIZE_Y,
  parameter logic [1:0] PHASE  = 2'd0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        raw,
  output logic [ADDR_W-1:0] address_out,
  output logic              out_sof,
  output logic              out_eol,
  output logic              frame_done,
  output logic              sof_err
);

  logic      r_in_ready;
  logic      r_out_valid;
  logic      r_skid_full;
  raw_beat_t r_out;
  raw_beat_t r_skid;

  logic              w_accept;
  logic              w_out_free;
  logic              w_skid_next;
  logic              w_px;
  logic              w_py;
  logic [ADDR_W-1:0] w_addr;
  logic              w_sof;
  logic              w_eol;
  logic              w_last;
  raw_beat_t         w_beat;

  assign w_accept   = in_valid && r_in_ready;
  assign w_out_free = !r_out_valid || out_ready;

  bayer_pos_counter #(
    .size_x (size_x),
    .size_y (size_y)
  ) u_pos (
    .clock     (clock),
    .reset     (reset),
    .i_adv     (w_accept),
    .i_sof     (in_sof),
    .o_px      (w_px),
    .o_py      (w_py),
    .o_addr    (w_addr),
    .o_sof     (w_sof),
    .o_eol     (w_eol),
    .o_last    (w_last),
    .o_sof_err (sof_err)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_beat      = '0;
    w_beat.addr = w_addr;
    w_beat.sof  = w_sof;
    w_beat.eol  = w_eol;
    w_beat.last = w_last;
    unique case (bayer_channel(w_px ^ PHASE[0], w_py ^ PHASE[1]))
      CH_R:    w_beat.raw = red;
      CH_B:    w_beat.raw = blue;
      default: w_beat.raw = green;
    endcase
  end

  // Skid occupancy after this edge; in_ready is its registered complement.
  always_comb begin
    w_skid_next = r_skid_full;
    if (w_out_free) begin
      if (r_skid_full && !w_accept) w_skid_next = 1'b0;
    end else if (w_accept) begin
      w_skid_next = 1'b1;
    end
  end

  // NOTE: payload registers are reset too, because raw/address_out must read 0 during reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_skid_full <= 1'b0;
      r_out       <= '0;
      r_skid      <= '0;
    end else begin
      if (w_out_free) begin
        if (r_skid_full) begin
          r_out       <= r_skid;
          r_out_valid <= 1'b1;
          if (w_accept) r_skid <= w_beat;
        end else begin
          r_out_valid <= w_accept;
          if (w_accept) r_out <= w_beat;
        end
      end else if (w_accept) begin
        r_skid <= w_beat;
      end
      r_skid_full <= w_skid_next;
      r_in_ready  <= !w_skid_next;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign raw         = r_out.raw;
  assign address_out = r_out.addr;
  assign out_sof     = r_out.sof;
  assign out_eol     = r_out.eol;
  assign frame_done  = r_out_valid && out_ready && r_out.last;

endmodule
